// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing with pixel enable, syncs, display enable and coordinates
module vga_timing_gen #(
    parameter int PCLK_DIV  = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic       h_sync,
    output logic       v_sync,
    output logic       DE,
    output logic [9:0] x_pixel,
    output logic [9:0] y_pixel,
    output logic       frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int PW = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PCLK_DIV - 1);
    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_FP_AT = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_AT = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_BP_AT = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_FP_AT = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_AT = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_BP_AT = 10'(V_VISIBLE + V_FP + V_SYNC);

    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;

    logic [PW-1:0] prescaler;
    logic [9:0]    h_count, v_count;
    logic          h_end, v_end;
    phase_t        h_phase, v_phase;

    // prescaler and raster counters; reset aborts the frame in place with nothing pending
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            h_count   <= '0;
            v_count   <= '0;
        end else begin
            prescaler <= p_tick ? '0 : prescaler + 1'b1;
            if (p_tick) begin
                h_count <= h_end ? '0 : h_count + 10'd1;
                if (h_end)
                    v_count <= v_end ? '0 : v_count + 10'd1;
            end
        end
    end

    // zero-latency decode of strobes, phases and the sync/enable outputs from the counters
    always_comb begin
        p_tick      = prescaler == PRE_MAX;
        h_end       = h_count == H_MAX;
        v_end       = v_count == V_MAX;
        h_phase     = h_count < H_FP_AT ? ACTIVE : h_count < H_SYNC_AT ? FRONT : h_count < H_BP_AT ? SYNC : BACK;
        v_phase     = v_count < V_FP_AT ? ACTIVE : v_count < V_SYNC_AT ? FRONT : v_count < V_BP_AT ? SYNC : BACK;
        h_sync      = h_phase != SYNC;
        v_sync      = v_phase != SYNC;
        DE          = h_phase == ACTIVE && v_phase == ACTIVE;
        frame_start = p_tick && h_end && v_end;
    end

    assign x_pixel = h_count;
    assign y_pixel = v_count;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized and scenario checks of vga_timing_gen against an arithmetic raster model
module tb_vga_timing_gen;
    localparam int SD = 3, SHV = 20, SHF = 3, SHS = 4, SHB = 5, SVV = 12, SVF = 2, SVS = 3, SVB = 4;
    localparam int SHT = SHV + SHF + SHS + SHB, SVT = SVV + SVF + SVS + SVB, SFP = SHT * SVT * SD;
    localparam int OVV = 12, OVF = 2, OVS = 2, OVB = 4, OVT = OVV + OVF + OVS + OVB, OFP = 800 * OVT;
    localparam logic [24:0] RST_VAL = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 20'd0};

    logic clk = 0;
    logic rst_d = 1, rst_s = 1, rst_o = 1;
    logic pt_d, hs_d, vs_d, de_d, fs_d, pt_s, hs_s, vs_s, de_s, fs_s, pt_o, hs_o, vs_o, de_o, fs_o;
    logic [9:0] x_d, y_d, x_s, y_s, x_o, y_o;
    logic [24:0] obs_d, obs_s, obs_o;
    int t_d, t_s, t_o;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_d (.clk(clk), .reset(rst_d), .p_tick(pt_d), .h_sync(hs_d), .v_sync(vs_d), .DE(de_d),
                        .x_pixel(x_d), .y_pixel(y_d), .frame_start(fs_d));
    vga_timing_gen #(.PCLK_DIV(SD), .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                     .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB))
        u_s (.clk(clk), .reset(rst_s), .p_tick(pt_s), .h_sync(hs_s), .v_sync(vs_s), .DE(de_s),
             .x_pixel(x_s), .y_pixel(y_s), .frame_start(fs_s));
    vga_timing_gen #(.PCLK_DIV(1), .V_VISIBLE(OVV), .V_FP(OVF), .V_SYNC(OVS), .V_BP(OVB))
        u_o (.clk(clk), .reset(rst_o), .p_tick(pt_o), .h_sync(hs_o), .v_sync(vs_o), .DE(de_o),
             .x_pixel(x_o), .y_pixel(y_o), .frame_start(fs_o));

    assign obs_d = {pt_d, hs_d, vs_d, de_d, fs_d, x_d, y_d};
    assign obs_s = {pt_s, hs_s, vs_s, de_s, fs_s, x_s, y_s};
    assign obs_o = {pt_o, hs_o, vs_o, de_o, fs_o, x_o, y_o};

    // elapsed clock edges since each instance left reset
    always @(posedge clk or posedge rst_d) if (rst_d) t_d <= 0; else t_d <= t_d + 1;
    always @(posedge clk or posedge rst_s) if (rst_s) t_s <= 0; else t_s <= t_s + 1;
    always @(posedge clk or posedge rst_o) if (rst_o) t_o <= 0; else t_o <= t_o + 1;

    function automatic logic [24:0] model(int t, int d, int hv, int hf, int hs, int hb,
                                          int vv, int vf, int vs, int vb);
        int ht, vt, pix, x, y;
        logic pt;
        ht  = hv + hf + hs + hb;
        vt  = vv + vf + vs + vb;
        pix = t / d;
        x   = pix % ht;
        y   = (pix / ht) % vt;
        pt  = (t % d) == d - 1;
        return {pt, !(x >= hv + hf && x < hv + hf + hs), !(y >= vv + vf && y < vv + vf + vs),
                x < hv && y < vv, pt && x == ht - 1 && y == vt - 1, 10'(x), 10'(y)};
    endfunction

    function automatic logic [24:0] exp_d(int t);
        return model(t, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction
    function automatic logic [24:0] exp_s(int t);
        return model(t, SD, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
    endfunction
    function automatic logic [24:0] exp_o(int t);
        return model(t, 1, 640, 16, 96, 48, OVV, OVF, OVS, OVB);
    endfunction

    task automatic pulse_rst_s();
        rst_s = 1;
        @(posedge clk);
        #1 rst_s = 0;
    endtask

    task automatic test_reset();
        int n;
        rst_d = 1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (obs_d !== RST_VAL) begin errors++; $display("FAIL reset_hold got %h want %h", obs_d, RST_VAL); end
        @(posedge clk);
        #1 rst_d = 0;
        @(negedge clk);
        checks++;
        if (obs_d !== RST_VAL) begin errors++; $display("FAIL reset_release got %h want %h", obs_d, RST_VAL); end
        n = 0;
        while (!pt_d && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (n !== 3 || x_d !== 10'd0) begin errors++; $display("FAIL first_tick got edges=%0d x=%0d want edges=3 x=0", n, x_d); end
        @(negedge clk);
        checks++;
        if (x_d !== 10'd1 || pt_d !== 1'b0) begin errors++; $display("FAIL x_step got x=%0d pt=%b want x=1 pt=0", x_d, pt_d); end
    endtask

    task automatic test_line_timing();
        int de_fall = -1, hs_fall = -1, hs_rise = -1, wrap_t = -1, wrap_y = -1, prev_x = 0;
        logic prev_de = 1, prev_hs = 1;
        rst_d = 1;
        @(posedge clk);
        #1 rst_d = 0;
        for (int i = 0; i < 6410; i++) begin
            @(negedge clk);
            checks++;
            if (obs_d !== exp_d(t_d)) begin errors++; $display("FAIL line_model t=%0d got %h want %h", t_d, obs_d, exp_d(t_d)); end
            if (prev_de && !de_d && de_fall < 0) de_fall = t_d;
            if (prev_hs && !hs_d && hs_fall < 0) hs_fall = t_d;
            if (!prev_hs && hs_d && hs_rise < 0) hs_rise = t_d;
            if (prev_x == 799 && x_d == 10'd0 && wrap_t < 0) begin wrap_t = t_d; wrap_y = int'(y_d); end
            prev_de = de_d; prev_hs = hs_d; prev_x = int'(x_d);
        end
        checks++;
        if (de_fall != 2560) begin errors++; $display("FAIL de_fall got %0d want 2560", de_fall); end
        checks++;
        if (hs_fall != 2624) begin errors++; $display("FAIL hsync_fall got %0d want 2624", hs_fall); end
        checks++;
        if (hs_rise != 3008) begin errors++; $display("FAIL hsync_rise got %0d want 3008", hs_rise); end
        checks++;
        if (wrap_t != 3200 || wrap_y != 1) begin errors++; $display("FAIL line_wrap got t=%0d y=%0d want t=3200 y=1", wrap_t, wrap_y); end
    endtask

    task automatic test_frame_timing();
        int fs_t[4];
        int fs_n = 0, vlow = 0, dticks = 0;
        pulse_rst_s();
        for (int i = 0; i < 2 * SFP + 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs_s !== exp_s(t_s)) begin errors++; $display("FAIL frame_model t=%0d got %h want %h", t_s, obs_s, exp_s(t_s)); end
            if (fs_s && fs_n < 4) begin fs_t[fs_n] = t_s; fs_n++; end
            if (t_s < SFP) begin
                if (!vs_s) vlow++;
                if (de_s && pt_s) dticks++;
            end
        end
        checks++;
        if (fs_n != 2 || fs_t[0] != SFP - 1 || fs_t[1] != 2 * SFP - 1)
            begin errors++; $display("FAIL frame_start got n=%0d t0=%0d t1=%0d want n=2 t0=%0d t1=%0d", fs_n, fs_t[0], fs_t[1], SFP - 1, 2 * SFP - 1); end
        checks++;
        if (vlow != SVS * SHT * SD) begin errors++; $display("FAIL vsync_width got %0d want %0d", vlow, SVS * SHT * SD); end
        checks++;
        if (dticks != SHV * SVV) begin errors++; $display("FAIL de_ticks got %0d want %0d", dticks, SHV * SVV); end
    endtask

    task automatic test_free_run();
        int frames = 0, ticks = 0, max_x = 0, max_y = 0;
        pulse_rst_s();
        for (int i = 0; i < 3 * SFP; i++) begin
            @(negedge clk);
            if (int'(x_s) > max_x) max_x = int'(x_s);
            if (int'(y_s) > max_y) max_y = int'(y_s);
            if (de_s && pt_s) ticks++;
            if (fs_s) begin
                frames++;
                checks++;
                if (ticks != SHV * SVV) begin errors++; $display("FAIL frame_de_ticks frame=%0d got %0d want %0d", frames, ticks, SHV * SVV); end
                ticks = 0;
            end
        end
        checks++;
        if (frames != 3 || max_x != SHT - 1 || max_y != SVT - 1)
            begin errors++; $display("FAIL free_run got frames=%0d maxx=%0d maxy=%0d want 3 %0d %0d", frames, max_x, max_y, SHT - 1, SVT - 1); end
    endtask

    task automatic test_mid_reset();
        int wrap_t = -1, fs_n = 0, fs_first = -1, prev_x = 0;
        logic found = 0;
        pulse_rst_s();
        for (int i = 0; i < SFP && !found; i++) begin
            @(negedge clk);
            found = x_s == 10'd10 && y_s == 10'd5;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL mid_seek got x=%0d y=%0d want x=10 y=5", x_s, y_s); end
        #2 rst_s = 1;
        #1;
        checks++;
        if (obs_s !== RST_VAL) begin errors++; $display("FAIL mid_async got %h want %h", obs_s, RST_VAL); end
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (obs_s !== RST_VAL) begin errors++; $display("FAIL mid_hold got %h want %h", obs_s, RST_VAL); end
        end
        @(posedge clk);
        #1 rst_s = 0;
        for (int i = 0; i < SFP + 5; i++) begin
            @(negedge clk);
            checks++;
            if (obs_s !== exp_s(t_s)) begin errors++; $display("FAIL mid_model t=%0d got %h want %h", t_s, obs_s, exp_s(t_s)); end
            if (prev_x == SHT - 1 && x_s == 10'd0 && wrap_t < 0) wrap_t = t_s;
            if (fs_s) begin fs_n++; if (fs_first < 0) fs_first = t_s; end
            prev_x = int'(x_s);
        end
        checks++;
        if (wrap_t != SHT * SD) begin errors++; $display("FAIL mid_line got %0d want %0d", wrap_t, SHT * SD); end
        checks++;
        if (fs_n != 1 || fs_first != SFP - 1) begin errors++; $display("FAIL mid_frame got n=%0d t=%0d want n=1 t=%0d", fs_n, fs_first, SFP - 1); end
    endtask

    task automatic test_pclk1();
        int pt_low = 0, hlow = 0, vlow = 0, fs_n = 0, fs_first = -1, wrap_t = -1, prev_x = 0;
        rst_o = 1;
        @(posedge clk);
        #1 rst_o = 0;
        for (int i = 0; i < OFP + 805; i++) begin
            @(negedge clk);
            checks++;
            if (obs_o !== exp_o(t_o)) begin errors++; $display("FAIL div1_model t=%0d got %h want %h", t_o, obs_o, exp_o(t_o)); end
            if (!pt_o) pt_low++;
            if (!hs_o && t_o < 800) hlow++;
            if (!vs_o && t_o < OFP) vlow++;
            if (prev_x == 799 && x_o == 10'd0 && wrap_t < 0) wrap_t = t_o;
            if (fs_s === 1'bx) pt_low++;
            if (fs_o) begin fs_n++; if (fs_first < 0) fs_first = t_o; end
            prev_x = int'(x_o);
        end
        checks++;
        if (pt_low != 0) begin errors++; $display("FAIL div1_tick got %0d low cycles want 0", pt_low); end
        checks++;
        if (wrap_t != 800 || hlow != 96) begin errors++; $display("FAIL div1_line got wrap=%0d hlow=%0d want 800 96", wrap_t, hlow); end
        checks++;
        if (vlow != 1600) begin errors++; $display("FAIL div1_vsync got %0d want 1600", vlow); end
        checks++;
        if (fs_n != 1 || fs_first != OFP - 1) begin errors++; $display("FAIL div1_frame got n=%0d t=%0d want n=1 t=%0d", fs_n, fs_first, OFP - 1); end
    endtask

    task automatic test_random_reset();
        int n, h;
        pulse_rst_s();
        for (int k = 0; k < 8; k++) begin
            n = int'($urandom_range(20, 1200));
            repeat (n) begin
                @(negedge clk);
                checks++;
                if (obs_s !== exp_s(t_s)) begin errors++; $display("FAIL rand_model t=%0d got %h want %h", t_s, obs_s, exp_s(t_s)); end
            end
            #($urandom_range(1, 4)) rst_s = 1;
            h = int'($urandom_range(1, 3));
            repeat (h) begin
                @(posedge clk);
                @(negedge clk);
                checks++;
                if (obs_s !== RST_VAL) begin errors++; $display("FAIL rand_reset got %h want %h", obs_s, RST_VAL); end
            end
            @(posedge clk);
            #1 rst_s = 0;
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_free_run();
        test_mid_reset();
        test_pclk1();
        test_random_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
